// File: rtl/mdu_unit_pkg.sv
// rtl/mdu_unit_pkg.sv - MDU operation codes and default latencies shared with the control decoder
package mdu_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MTHI  = 4'b0101;
  localparam logic [3:0] MDU_MTLO  = 4'b0110;
  localparam logic [3:0] MDU_MFHI  = 4'b0111;
  localparam logic [3:0] MDU_MFLO  = 4'b1000;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // mult/multu/div/divu occupy the unit for several cycles
  function automatic logic is_long_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit product and quotient/remainder per MDU op
module mdu_arith
  import mdu_unit_pkg::*;
(
  input  logic [31:0] src_A,
  input  logic [31:0] src_B,
  input  logic [3:0]  MDUOp,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic               w_b_zero;
  logic               w_ovf;
  logic signed [31:0] w_sdvd;
  logic signed [31:0] w_sdvs;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic        [31:0] w_udvs;
  logic        [31:0] w_uquo;
  logic        [31:0] w_urem;

  assign w_sprod = $signed({{32{src_A[31]}}, src_A}) * $signed({{32{src_B[31]}}, src_B});
  assign w_uprod = {32'd0, src_A} * {32'd0, src_B};

  // Zero divisor and INT_MIN/-1 both divide by 1 instead; the latter then yields LO=INT_MIN, HI=0
  assign w_b_zero = (src_B == 32'd0);
  assign w_ovf    = (src_A == 32'h8000_0000) && (src_B == 32'hFFFF_FFFF);
  assign w_sdvd   = $signed(src_A);
  assign w_sdvs   = (w_b_zero || w_ovf) ? 32'sd1 : $signed(src_B);
  assign w_udvs   = w_b_zero ? 32'd1 : src_B;
  assign w_squo   = w_sdvd / w_sdvs;
  assign w_srem   = w_sdvd % w_sdvs;
  assign w_uquo   = src_A / w_udvs;
  assign w_urem   = src_A % w_udvs;

  assign o_div_zero = is_div_op(MDUOp) && w_b_zero;

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    case (MDUOp)
      MDU_MULT:  {o_hi, o_lo} = w_sprod;
      MDU_MULTU: {o_hi, o_lo} = w_uprod;
      MDU_DIV:   begin o_hi = w_srem; o_lo = w_squo; end
      MDU_DIVU:  begin o_hi = w_urem; o_lo = w_uquo; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning HI/LO for the E stage
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_A,
  input  logic [31:0] src_B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] E_MDO,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_we;

  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;
  logic          w_div_zero;
  logic          w_accept;

  mdu_arith u_arith (
    .src_A      (src_A),
    .src_B      (src_B),
    .MDUOp      (MDUOp),
    .o_hi       (w_res_hi),
    .o_lo       (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  assign w_accept = start && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else if (w_accept) begin
      if (is_long_op(MDUOp)) begin
        r_cnt     <= is_div_op(MDUOp) ? CW'(DIV_CYC) : CW'(MULT_CYC);
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_we <= !w_div_zero;
      end else if (MDUOp == MDU_MTHI) begin
        r_hi <= src_A;
      end else if (MDUOp == MDU_MTLO) begin
        r_lo <= src_A;
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      // A zero-divisor divide runs its full latency but leaves HI/LO untouched
      if ((r_cnt == CW'(1)) && r_pend_we) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  always_comb begin
    E_MDO = 32'd0;
    if (MDUOp == MDU_MFHI)      E_MDO = r_hi;
    else if (MDUOp == MDU_MFLO) E_MDO = r_lo;
  end

  assign busy = (r_cnt != '0);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
